// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encodings for the UART command receiver.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_FREQ   = 8'h01;
  localparam logic [7:0] CMD_AMP    = 8'h02;
  localparam logic [7:0] FREQ_RESET = 8'h01;
  localparam logic [7:0] AMP_RESET  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    WAIT_CMD  = 2'd1,
    WAIT_DATA = 2'd2
  } parse_state_e;

  // True for the command codes that carry a data byte.
  function automatic logic is_known_cmd(input logic [7:0] b);
    return (b == CMD_FREQ) || (b == CMD_AMP);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizes the raw line and samples each bit mid-period.
module uart_rx_byte
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_done,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_r;
  logic             sync2_r;
  rx_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_done_r;
  logic             frame_err_r;
  logic             busy_r;

  // Two-flop synchronizer; flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk1) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
    end
  end

  // Bit-timing state machine: start check at half a bit, then one sample per bit period.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!sync2_r) begin
            state_r   <= START;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            busy_r    <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r <= '0;
            if (!sync2_r) begin
              state_r <= DATA;
            end else begin
              // Line went back high: treat as a glitch, not a byte.
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= '0;
            shift_r <= {sync2_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= '0;
            state_r <= IDLE;
            busy_r  <= 1'b0;
            if (sync2_r) begin
              byte_done_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_done = byte_done_r;
  assign rx_data   = shift_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: parses A5/CMD/DATA packets into freq_step and amplitude.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] freq_step,
  output logic [7:0] amplitude,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       rx_busy
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_LIMIT);

  logic         byte_done_s;
  logic [7:0]   rx_data_s;
  logic         frame_err_s;
  logic         busy_s;
  logic         timeout_s;

  parse_state_e pstate_r;
  logic [7:0]   cmd_r;
  logic [7:0]   freq_r;
  logic [7:0]   amp_r;
  logic         cmd_valid_r;
  logic         cmd_err_r;
  logic [TO_W-1:0] to_cnt_r;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk1      (clk1),
    .rst       (rst),
    .rxd       (uart_rxd),
    .byte_done (byte_done_s),
    .rx_data   (rx_data_s),
    .frame_err (frame_err_s),
    .busy      (busy_s)
  );

  // Inter-byte gap expires on the last cycle of the allowed window.
  always_comb begin
    timeout_s = 1'b0;
    if (to_cnt_r == TO_LAST) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Gap counter: cleared by each byte and while idle, saturates instead of wrapping.
  always_ff @(posedge clk1) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if (byte_done_s || (pstate_r == WAIT_SYNC)) begin
      to_cnt_r <= '0;
    end else if (to_cnt_r != TO_MAX) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Packet parser with registered output updates and one-cycle event pulses.
  always_ff @(posedge clk1) begin
    if (rst) begin
      pstate_r    <= WAIT_SYNC;
      cmd_r       <= CMD_FREQ;
      freq_r      <= FREQ_RESET;
      amp_r       <= AMP_RESET;
      cmd_valid_r <= 1'b0;
      cmd_err_r   <= 1'b0;
    end else begin
      cmd_valid_r <= 1'b0;
      cmd_err_r   <= 1'b0;
      case (pstate_r)
        WAIT_SYNC: begin
          if (byte_done_s && (rx_data_s == SYNC_BYTE)) begin
            pstate_r <= WAIT_CMD;
          end
        end
        WAIT_CMD: begin
          if (byte_done_s) begin
            if (rx_data_s == SYNC_BYTE) begin
              // Repeated sync: stay put so the next byte is taken as the command.
              pstate_r <= WAIT_CMD;
            end else if (is_known_cmd(rx_data_s)) begin
              cmd_r    <= rx_data_s;
              pstate_r <= WAIT_DATA;
            end else begin
              cmd_err_r <= 1'b1;
              pstate_r  <= WAIT_SYNC;
            end
          end else if (frame_err_s || timeout_s) begin
            pstate_r <= WAIT_SYNC;
          end
        end
        WAIT_DATA: begin
          if (byte_done_s) begin
            case (cmd_r)
              CMD_FREQ: begin
                freq_r      <= rx_data_s;
                cmd_valid_r <= 1'b1;
              end
              CMD_AMP: begin
                amp_r       <= rx_data_s;
                cmd_valid_r <= 1'b1;
              end
              default: begin
                cmd_valid_r <= 1'b0;
              end
            endcase
            pstate_r <= WAIT_SYNC;
          end else if (frame_err_s || timeout_s) begin
            pstate_r <= WAIT_SYNC;
          end
        end
        default: begin
          pstate_r <= WAIT_SYNC;
        end
      endcase
    end
  end

  assign freq_step = freq_r;
  assign amplitude = amp_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_err   = cmd_err_r;
  assign frame_err = frame_err_s;
  assign rx_busy   = busy_s;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed testbench for uart_cmd_rx using a short bit period.
module tb_uart_cmd_rx;

  localparam int C = 16;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] freq_step;
  logic [7:0] amplitude;
  logic       cmd_valid;
  logic       frame_err;
  logic       cmd_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cv_count = 0;
  int fe_count = 0;
  int ce_count = 0;
  int consec = 0;
  int last_cv_cyc = -1;
  logic prev_cv = 1'b0;
  logic prev_fe = 1'b0;
  logic prev_ce = 1'b0;

  uart_cmd_rx #(
    .CLKS_PER_BIT(C),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk1      (clk1),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .freq_step (freq_step),
    .amplitude (amplitude),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .cmd_err   (cmd_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk1) begin
    if (cmd_valid === 1'b1) begin
      cv_count++;
      last_cv_cyc = cyc;
      if (prev_cv === 1'b1) consec++;
    end
    if (frame_err === 1'b1) begin
      fe_count++;
      if (prev_fe === 1'b1) consec++;
    end
    if (cmd_err === 1'b1) begin
      ce_count++;
      if (prev_ce === 1'b1) consec++;
    end
    prev_cv = cmd_valid;
    prev_fe = frame_err;
    prev_ce = cmd_err;
  end

  task automatic send_bit(input logic b);
    uart_rxd = b;
    repeat (C) @(posedge clk1);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, output int start_cyc);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle_cycles(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic test_reset;
    int cv0, fe0, ce0;
    rst = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    checks++; if (freq_step !== 8'h01) begin errors++; $display("FAIL reset_freq got %h want %h", freq_step, 8'h01); end
    checks++; if (amplitude !== 8'hFF) begin errors++; $display("FAIL reset_amp got %h want %h", amplitude, 8'hFF); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got %b want 0", cmd_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    rst = 1'b0;
    cv0 = cv_count; fe0 = fe_count; ce0 = ce_count;
    idle_cycles(1000);
    checks++; if (freq_step !== 8'h01) begin errors++; $display("FAIL idle_freq got %h want %h", freq_step, 8'h01); end
    checks++; if (amplitude !== 8'hFF) begin errors++; $display("FAIL idle_amp got %h want %h", amplitude, 8'hFF); end
    checks++; if ((cv_count - cv0) + (fe_count - fe0) + (ce_count - ce0) !== 0) begin
      errors++; $display("FAIL idle_pulses got %0d want 0", (cv_count - cv0) + (fe_count - fe0) + (ce_count - ce0)); end
  endtask

  task automatic test_back_to_back;
    int s0, s1, s2, cv0, exp_cyc;
    cv0 = cv_count;
    send_byte(8'hA5, 1'b1, s0);
    send_byte(8'h01, 1'b1, s1);
    send_byte(8'h10, 1'b1, s2);
    idle_cycles(4);
    // Start edge reaches the FSM 3 edges later, stop sample C/2 + 9C after that, pulse one more.
    exp_cyc = s2 + 4 + C / 2 + 9 * C;
    checks++; if (freq_step !== 8'h10) begin errors++; $display("FAIL b2b_freq got %h want %h", freq_step, 8'h10); end
    checks++; if (amplitude !== 8'hFF) begin errors++; $display("FAIL b2b_amp got %h want %h", amplitude, 8'hFF); end
    checks++; if (cv_count - cv0 !== 1) begin errors++; $display("FAIL b2b_cv_count got %0d want 1", cv_count - cv0); end
    checks++; if (last_cv_cyc !== exp_cyc) begin errors++; $display("FAIL b2b_cv_timing got %0d want %0d", last_cv_cyc, exp_cyc); end
  endtask

  task automatic test_amp_and_bad_cmd;
    int s, cv0, ce0;
    cv0 = cv_count;
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h02, 1'b1, s);
    send_byte(8'h80, 1'b1, s);
    idle_cycles(4);
    checks++; if (amplitude !== 8'h80) begin errors++; $display("FAIL amp_load got %h want %h", amplitude, 8'h80); end
    checks++; if (cv_count - cv0 !== 1) begin errors++; $display("FAIL amp_cv_count got %0d want 1", cv_count - cv0); end
    cv0 = cv_count; ce0 = ce_count;
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h07, 1'b1, s);
    idle_cycles(4);
    checks++; if (ce_count - ce0 !== 1) begin errors++; $display("FAIL bad_cmd_err_count got %0d want 1", ce_count - ce0); end
    checks++; if (cv_count - cv0 !== 0) begin errors++; $display("FAIL bad_cmd_cv_count got %0d want 0", cv_count - cv0); end
    checks++; if (amplitude !== 8'h80) begin errors++; $display("FAIL bad_cmd_amp got %h want %h", amplitude, 8'h80); end
    checks++; if (freq_step !== 8'h10) begin errors++; $display("FAIL bad_cmd_freq got %h want %h", freq_step, 8'h10); end
  endtask

  task automatic test_frame_err;
    int s, cv0, fe0;
    cv0 = cv_count; fe0 = fe_count;
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h01, 1'b1, s);
    send_byte(8'h55, 1'b0, s);
    idle_cycles(2 * C);
    checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL frame_err_count got %0d want 1", fe_count - fe0); end
    checks++; if (freq_step !== 8'h10) begin errors++; $display("FAIL frame_err_freq got %h want %h", freq_step, 8'h10); end
    checks++; if (cv_count - cv0 !== 0) begin errors++; $display("FAIL frame_err_cv got %0d want 0", cv_count - cv0); end
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h01, 1'b1, s);
    send_byte(8'h22, 1'b1, s);
    idle_cycles(4);
    checks++; if (freq_step !== 8'h22) begin errors++; $display("FAIL after_frame_freq got %h want %h", freq_step, 8'h22); end
  endtask

  task automatic test_timeout;
    int s, cv0;
    cv0 = cv_count;
    send_byte(8'hA5, 1'b1, s);
    idle_cycles(33 * C);
    send_byte(8'h01, 1'b1, s);
    send_byte(8'h33, 1'b1, s);
    idle_cycles(4);
    checks++; if (freq_step !== 8'h22) begin errors++; $display("FAIL timeout_freq got %h want %h", freq_step, 8'h22); end
    checks++; if (cv_count - cv0 !== 0) begin errors++; $display("FAIL timeout_cv got %0d want 0", cv_count - cv0); end
    cv0 = cv_count;
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h01, 1'b1, s);
    send_byte(8'hA5, 1'b1, s);
    idle_cycles(4);
    checks++; if (freq_step !== 8'hA5) begin errors++; $display("FAIL resync_freq got %h want %h", freq_step, 8'hA5); end
    checks++; if (cv_count - cv0 !== 1) begin errors++; $display("FAIL resync_cv got %0d want 1", cv_count - cv0); end
  endtask

  task automatic test_glitch_reset;
    int s, cv0, fe0, ce0;
    cv0 = cv_count; fe0 = fe_count; ce0 = ce_count;
    uart_rxd = 1'b0;
    repeat (4) @(posedge clk1);
    #1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got %b want 1", rx_busy); end
    @(posedge clk1);
    #1;
    idle_cycles(2 * C);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got %b want 0", rx_busy); end
    // Put the parser into WAIT_CMD, then abandon a byte mid-flight with reset.
    send_byte(8'hA5, 1'b1, s);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midbyte_busy got %b want 1", rx_busy); end
    rst = 1'b1;
    uart_rxd = 1'b1;
    @(posedge clk1);
    #1;
    rst = 1'b0;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", rx_busy); end
    checks++; if (freq_step !== 8'h01) begin errors++; $display("FAIL post_reset_freq got %h want %h", freq_step, 8'h01); end
    send_byte(8'h02, 1'b1, s);
    send_byte(8'h77, 1'b1, s);
    idle_cycles(2 * C);
    checks++; if (amplitude !== 8'hFF) begin errors++; $display("FAIL post_reset_amp got %h want %h", amplitude, 8'hFF); end
    checks++; if ((cv_count - cv0) + (fe_count - fe0) + (ce_count - ce0) !== 0) begin
      errors++; $display("FAIL glitch_reset_pulses got %0d want 0", (cv_count - cv0) + (fe_count - fe0) + (ce_count - ce0)); end
    checks++; if (consec !== 0) begin errors++; $display("FAIL pulse_width got %0d stretched pulses want 0", consec); end
  endtask

  initial begin
    #3;
    test_reset();
    test_back_to_back();
    test_amp_and_bad_cmd();
    test_frame_err();
    test_timeout();
    test_glitch_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
